// File: rtl/spi_main_ctrl_if.sv
// Host/bus signal bundle for the dual-slave AES SPI controller.
// The master modport is the controller's view; slave is the host/bus side.
interface spi_main_ctrl_if;
  logic         start;
  logic         sel;
  logic [0:257] tx;
  logic [0:1]   miso;
  logic [0:127] rx;
  logic [0:1]   cs_n;
  logic         sclk;
  logic         mosi;
  logic         done;

  modport master (
    input  start, sel, tx, miso,
    output rx, cs_n, sclk, mosi, done
  );

  modport slave (
    output start, sel, tx, miso,
    input  rx, cs_n, sclk, mosi, done
  );
endinterface

// File: rtl/spi_main_ctrl.sv
// SPI master driving an encrypt (0) and a decrypt (1) AES slave through a
// repeating key-load / block-write / result-read cycle, one bit per clk.
module spi_main_ctrl (
  input  logic           clk,
  input  logic           rst,
  spi_main_ctrl_if.master bus
);
  localparam int TX_W  = 258;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {PH_KEY, PH_BLK, PH_RD} phase_t;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_KEY:  return PH_BLK;
      PH_BLK:  return PH_RD;
      default: return PH_KEY;
    endcase
  endfunction

  state_t            state_q;
  phase_t            phase_q [0:1];
  phase_t            cur_ph_q;
  logic              sel_q;
  logic [0:TX_W-1]   shreg_q;
  logic [8:0]        len_q;
  logic [8:0]        cnt_q;
  logic [0:1]        cs_n_q;
  logic              mosi_q;
  logic              done_q;
  logic [0:BLK_W-1]  rx_q;
  logic              sclk_en_q;

  // Serial image (first bit at index 0) and bit count for a start this cycle.
  phase_t          start_ph;
  logic [0:TX_W-1] load_img;
  logic [8:0]      load_len;

  always_comb begin
    start_ph = phase_q[bus.sel];
    load_img = '0;
    load_len = 9'd128;
    case (start_ph)
      PH_KEY: begin
        case (bus.tx[0:1])
          2'b00: begin
            load_img = {bus.tx[0:1], bus.tx[130:257], 128'b0};
            load_len = 9'd130;
          end
          2'b01: begin
            load_img = {bus.tx[0:1], bus.tx[66:257], 64'b0};
            load_len = 9'd194;
          end
          default: begin
            load_img = bus.tx;
            load_len = 9'd258;
          end
        endcase
      end
      PH_BLK:  load_img = {bus.tx[130:257], 130'b0};
      default: load_img = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q[0] <= PH_KEY;
      phase_q[1] <= PH_KEY;
      cur_ph_q   <= PH_KEY;
      sel_q      <= 1'b0;
      shreg_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      cs_n_q     <= 2'b11;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sel_q    <= bus.sel;
            cur_ph_q <= start_ph;
            len_q    <= load_len;
            cnt_q    <= 9'd1;
            mosi_q   <= load_img[0];
            shreg_q  <= load_img << 1;
            cs_n_q   <= bus.sel ? 2'b10 : 2'b01;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Each posedge here ends a bit slot, so it is also the sample point.
          if (cur_ph_q == PH_RD)
            rx_q <= {rx_q[1:BLK_W-1], bus.miso[sel_q]};
          if (cnt_q == len_q) begin
            state_q        <= S_DONE;
            cs_n_q         <= 2'b11;
            mosi_q         <= 1'b0;
            done_q         <= 1'b1;
            phase_q[sel_q] <= next_phase(cur_ph_q);
          end else begin
            mosi_q  <= shreg_q[0];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + 9'd1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the enable is retimed on the falling edge so the AND gate below only
  // sees it change while clk is low, which keeps sclk free of runt pulses.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) sclk_en_q <= 1'b0;
    else     sclk_en_q <= (state_q == S_SHIFT);
  end

  assign bus.sclk = clk & sclk_en_q;
  assign bus.cs_n = cs_n_q;
  assign bus.mosi = mosi_q;
  assign bus.done = done_q;
  assign bus.rx   = rx_q;
endmodule

// File: tb/tb_spi_main_ctrl.sv
// Randomised scoreboard bench for spi_main_ctrl: stimulus pushes expected
// transfers, a negedge monitor captures the bus and compares at each done.
module tb_spi_main_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_main_ctrl_if bus ();
  spi_main_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic         sel;
    int           n;
    logic [0:257] bits;
    logic [0:127] rx;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           step_m [2];
  logic [0:127] last_rx;
  logic [0:127] slave_word [2];
  int           scnt [2];
  int           cyc = 0;
  int           sclk_n = 0;

  task automatic check(input string name, input logic [257:0] act, input logic [257:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [0:257] rand_tx();
    logic [287:0] w;
    for (int i = 0; i < 9; i++) w[i*32 +: 32] = $urandom();
    return w[257:0];
  endfunction

  function automatic logic [0:127] rand128();
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge bus.sclk) sclk_n++;

  // Slave model: shifts its word out on the falling edge while selected.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (bus.cs_n[s] == 1'b0) begin
        bus.miso[s] = slave_word[s][scnt[s] % 128];
        scnt[s]++;
      end else begin
        scnt[s] = 0;
        bus.miso[s] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: capture mosi while a slave is selected, score on done.
  logic [0:257] cap = '0;
  int           cap_n = 0;
  int           sclk_base = 0;
  logic [0:1]   cs_seen = 2'b11;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cap_n = 0;
      cap = '0;
      sclk_base = sclk_n;
    end else if (bus.cs_n != 2'b11) begin
      if (cap_n < 258) cap[cap_n] = bus.mosi;
      cap_n++;
      cs_seen = bus.cs_n;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with no transaction pending, required none");
      end else begin
        e = exp_q.pop_front();
        check("cs_select", cs_seen, e.sel ? 2'b10 : 2'b01);
        check("bit_count", cap_n, e.n);
        check("mosi_stream", cap, e.bits);
        check("rx_value", bus.rx, e.rx);
        check("sclk_edges", sclk_n - sclk_base, e.n);
      end
      cap_n = 0;
      cap = '0;
      sclk_base = sclk_n;
    end
  end

  // Reference model: expected serial stream computed from the transfer rules.
  function automatic exp_t model_txn(input logic s, input logic [0:257] t, input logic [0:127] rd);
    exp_t e;
    int   k;
    e.sel  = s;
    e.bits = '0;
    e.rx   = last_rx;
    case (step_m[s])
      0: begin
        k = (t[0:1] == 2'b00) ? 128 : (t[0:1] == 2'b01) ? 192 : 256;
        e.n = 2 + k;
        e.bits[0] = t[0];
        e.bits[1] = t[1];
        for (int j = 0; j < k; j++) e.bits[2+j] = t[258-k+j];
      end
      1: begin
        e.n = 128;
        for (int j = 0; j < 128; j++) e.bits[j] = t[130+j];
      end
      default: begin
        e.n  = 128;
        e.rx = rd;
      end
    endcase
    return e;
  endfunction

  // mode: 0 plain, 1 perturb sel/tx after start, 2 hold start, 3 extra start mid-shift
  task automatic run_txn(input logic s, input logic [0:257] t, input logic [0:127] rd, input int mode);
    exp_t e;
    int   t0;
    bit   got;
    if (step_m[s] == 2) repeat (70) @(posedge clk);
    e = model_txn(s, t, rd);
    step_m[s] = (step_m[s] + 1) % 3;
    last_rx = e.rx;
    slave_word[s] = rd;
    slave_word[!s] = rand128();
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sel   = s;
    bus.tx    = t;
    @(posedge clk); #1;
    t0 = cyc;
    if (mode != 2) bus.start = 1'b0;
    if (mode == 1) begin
      bus.sel = !s;
      bus.tx  = rand_tx();
    end
    if (mode == 2) begin
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b0;
    end
    if (mode == 3) begin
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b1;
      bus.sel = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done within 400 cycles, required done after %0d", e.n + 1);
    end else begin
      check("done_latency", cyc - t0, e.n);
    end
  endtask

  // Start a transfer and hit reset part-way through it.
  task automatic run_abort(input logic s, input logic [0:257] t);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sel   = s;
    bus.tx    = t;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("cs_n_async_reset", bus.cs_n, 2'b11);
    check("rx_async_reset", bus.rx, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    step_m[0] = 0;
    step_m[1] = 0;
    last_rx = '0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [0:257] t;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sel   = 1'b0;
    bus.tx    = '0;
    bus.miso  = '0;
    step_m[0] = 0;
    step_m[1] = 0;
    last_rx = '0;
    slave_word[0] = '0;
    slave_word[1] = '0;

    // 1. reset with start pulses present
    repeat (3) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      check("sclk_in_reset", bus.sclk, 1'b0);
      @(negedge clk);
      check("cs_n_in_reset", bus.cs_n, 2'b11);
      check("done_in_reset", bus.done, 1'b0);
      check("rx_in_reset", bus.rx, '0);
      check("mosi_in_reset", bus.mosi, 1'b0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("cs_n_idle_after_reset", bus.cs_n, 2'b11);
    check("done_idle_after_reset", bus.done, 1'b0);

    // 2-4. encrypt slave: 128-bit key, block, result read
    run_txn(1'b0, 258'h000102030405060708090a0b0c0d0e0f, rand128(), 0);
    run_txn(1'b0, 258'h00112233445566778899aabbccddeeff, rand128(), 0);
    run_txn(1'b0, rand_tx(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

    // 5. decrypt slave: 192-bit then 256-bit key loops
    t = rand_tx();
    t[0:1] = 2'b01;
    run_txn(1'b1, t, rand128(), 0);
    run_txn(1'b1, rand_tx(), rand128(), 0);
    run_txn(1'b1, rand_tx(), 128'h00112233445566778899aabbccddeeff, 0);
    t = rand_tx();
    t[0:1] = 2'b10;
    run_txn(1'b1, t, rand128(), 2);
    run_txn(1'b1, rand_tx(), rand128(), 1);
    run_txn(1'b1, rand_tx(), rand128(), 0);

    // 6. extra start during shift, then reset mid-block
    run_txn(1'b0, rand_tx(), rand128(), 3);
    run_abort(1'b0, rand_tx());
    t = rand_tx();
    t[0:1] = 2'b00;
    run_txn(1'b0, t, rand128(), 0);

    // randomised interleaving across both slaves
    for (int i = 0; i < 36; i++) begin
      run_txn(1'($urandom_range(0, 1)), rand_tx(), rand128(), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
